multi_lane_acc_controller: RTL and testbench

Parametrised successor to the fixed four-lane accumulator controller. Splits each packed input word into NUM_LANES unsigned lanes and accumulates each lane over a programmed number of words. Accumulation is internal, so no per-lane acc_core instances are needed. Sits between the input controller (valid/ready beats) and the output controller (valid/ready result), with a start/length command from the top module.

---
 rtl/multi_lane_acc_controller.sv | 140 ++++++++++++++
 tb/tb_multi_lane_acc_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_lane_acc_controller.sv
// Multi-lane accumulator controller.
// Splits each packed input word into NUM_LANES unsigned lanes and sums each
// lane over a commanded number of words. Accepted beats pass through a stage
// register first, so the last beat is added one cycle after its handshake.
// Each lane either saturates or wraps, and has a sticky overflow flag.
//
// state  | meaning
// IDLE   | waiting for start_i; ready_o=0, valid_o=0
// RUN    | accepting beats (ready_o=1) until the word count is reached
// DRAIN  | adding the last staged word; no beats accepted
// DONE   | result valid, held until result_ready_i
module multi_lane_acc_controller #(
    parameter int NUM_LANES = 4,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 12
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic [CNT_WIDTH-1:0]           num_words_i,
    input  logic                           sat_en_i,
    input  logic [NUM_LANES*IN_WIDTH-1:0]  data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic [NUM_LANES*ACC_WIDTH-1:0] result_o,
    output logic                           valid_o,
    input  logic                           result_ready_i,
    output logic [NUM_LANES-1:0]           ovf_o,
    output logic                           busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                         state_q;
    logic [CNT_WIDTH-1:0]           cnt_q;
    logic [CNT_WIDTH-1:0]           cnt_nxt;
    logic [CNT_WIDTH-1:0]           num_words_q;
    logic                           sat_q;
    logic [NUM_LANES*IN_WIDTH-1:0]  stage_q;
    logic                           stage_vld_q;
    logic [NUM_LANES*ACC_WIDTH-1:0] acc_q;
    logic [NUM_LANES*ACC_WIDTH-1:0] acc_add;
    logic [NUM_LANES-1:0]           ovf_q;
    logic [NUM_LANES-1:0]           ovf_add;
    logic                           beat_hs;

    assign beat_hs  = valid_i & ready_o;
    assign cnt_nxt  = cnt_q + 1'b1;
    assign result_o = acc_q;
    assign ovf_o    = ovf_q;

    // Per-lane adder: one extra bit catches the carry; saturate or wrap on it.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [ACC_WIDTH:0] sum;
        assign sum = {1'b0, acc_q[k*ACC_WIDTH +: ACC_WIDTH]}
                   + {{(ACC_WIDTH+1-IN_WIDTH){1'b0}}, stage_q[k*IN_WIDTH +: IN_WIDTH]};
        assign ovf_add[k] = sum[ACC_WIDTH];
        assign acc_add[k*ACC_WIDTH +: ACC_WIDTH] =
            (sum[ACC_WIDTH] && sat_q) ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    end

    // Sequencing FSM, beat staging and lane accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ready_o     <= 1'b0;
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
            cnt_q       <= '0;
            num_words_q <= '0;
            sat_q       <= 1'b0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= '0;
        end else begin
            // A staged word is added on the edge after its handshake.
            if (stage_vld_q) begin
                acc_q <= acc_add;
                ovf_q <= ovf_q | ovf_add;
            end
            stage_vld_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        acc_q       <= '0;
                        ovf_q       <= '0;
                        cnt_q       <= '0;
                        num_words_q <= num_words_i;
                        sat_q       <= sat_en_i;
                        busy_o      <= 1'b1;
                        if (num_words_i == '0) begin
                            state_q <= S_DONE;
                            valid_o <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            ready_o <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (beat_hs) begin
                        stage_q     <= data_i;
                        stage_vld_q <= 1'b1;
                        cnt_q       <= cnt_nxt;
                        if (cnt_nxt == num_words_q) begin
                            state_q <= S_DRAIN;
                            ready_o <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    state_q <= S_DONE;
                    valid_o <= 1'b1;
                end
                S_DONE: begin
                    if (result_ready_i) begin
                        state_q <= S_IDLE;
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_o <= 1'b0;
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_lane_acc_controller.sv
// Bench for multi_lane_acc_controller: directed jobs plus randomized jobs.
// Expected results come from an integer lane-sum model and are queued per job;
// a monitor pops and compares whenever a result transfer happens.
module tb_multi_lane_acc_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [11:0] num_words_i;
    logic        sat_en_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] result_o;
    logic        valid_o;
    logic        result_ready_i;
    logic [3:0]  ovf_o;
    logic        busy_o;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  ovf;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] beat_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    multi_lane_acc_controller #(
        .NUM_LANES(4), .IN_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_words_i(num_words_i),
        .sat_en_i(sat_en_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .result_o(result_o), .valid_o(valid_o), .result_ready_i(result_ready_i),
        .ovf_o(ovf_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer lane sums over the first nw queued beats.
    function automatic exp_t model(input int nw, input bit sat);
        exp_t        e;
        int          acc[4];
        int          s;
        logic [31:0] w;
        e = '0;
        for (int k = 0; k < 4; k++) acc[k] = 0;
        for (int i = 0; i < nw; i++) begin
            w = beat_q[i];
            for (int k = 0; k < 4; k++) begin
                s = acc[k] + int'(w[8*k +: 8]);
                if (s > 65535) begin
                    e.ovf[k] = 1'b1;
                    s = sat ? 65535 : s - 65536;
                end
                acc[k] = s;
            end
        end
        for (int k = 0; k < 4; k++) e.res[16*k +: 16] = 16'(acc[k]);
        return e;
    endfunction

    // Monitor: every completed result transfer is checked against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && valid_o && result_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got 0x%0h, required no result", result_o);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result_o, e.res);
                    check("ovf", 64'(ovf_o), 64'(e.ovf));
                end
            end
        end
    end

    // gap: 0 = back-to-back, 1 = toggling valid, 2 = random valid.
    task automatic feed(input int n, input int gap, input bit pulse);
        int idx = 0;
        int cyc = 0;
        bit hs;
        while (idx < n && cyc < 8*n + 50) begin
            case (gap)
                1:       valid_i = (cyc % 2 == 0);
                2:       valid_i = 1'($urandom_range(0, 1));
                default: valid_i = 1'b1;
            endcase
            data_i  = valid_i ? beat_q[idx] : $urandom;
            start_i = pulse && (cyc == 3);
            hs = valid_i && ready_o;
            tick();
            cyc++;
            if (hs) idx++;
        end
        valid_i = 1'b0;
        start_i = 1'b0;
        if (idx < n) check("feed_timeout", 64'(idx), 64'(n));
    endtask

    task automatic run_job(input int nw, input bit sat, input int gap, input bit pulse, input int hold);
        exp_t e;
        e = model(nw, sat);
        exp_q.push_back(e);
        start_i     = 1'b1;
        num_words_i = 12'(nw);
        sat_en_i    = sat;
        tick();
        start_i = 1'b0;
        check("busy_after_start", 64'(busy_o), 64'd1);
        if (nw == 0) begin
            check("zero_ready", 64'(ready_o), 64'd0);
            check("zero_valid", 64'(valid_o), 64'd1);
        end else begin
            check("ready_in_run", 64'(ready_o), 64'd1);
            feed(nw, gap, pulse);
            check("ready_drop", 64'(ready_o), 64'd0);
            check("valid_early", 64'(valid_o), 64'd0);
            tick();
            check("valid_latency", 64'(valid_o), 64'd1);
        end
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 64'(valid_o), 64'd1);
            check("hold_result", result_o, e.res);
            check("hold_ovf", 64'(ovf_o), 64'(e.ovf));
            start_i     = (h == 1);
            num_words_i = 12'd1;
            tick();
            start_i = 1'b0;
        end
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        check("valid_after_xfer", 64'(valid_o), 64'd0);
        check("busy_after_xfer", 64'(busy_o), 64'd0);
    endtask

    initial begin
        int nw;
        bit heavy;
        rst_n          = 1'b0;
        start_i        = 1'b0;
        num_words_i    = '0;
        sat_en_i       = 1'b0;
        data_i         = '0;
        valid_i        = 1'b0;
        result_ready_i = 1'b0;
        tick();
        tick();
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ovf", 64'(ovf_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        rst_n = 1'b1;
        tick();

        // Three back-to-back beats of 0x04030201.
        beat_q = {32'h04030201, 32'h04030201, 32'h04030201};
        run_job(3, 1'b0, 0, 1'b0, 0);

        // 300 beats of 0xFF in lane 0, saturating then wrapping.
        beat_q.delete();
        for (int i = 0; i < 300; i++) beat_q.push_back(32'h000000FF);
        run_job(300, 1'b1, 0, 1'b0, 1);
        run_job(300, 1'b0, 0, 1'b0, 1);

        // Zero-length job.
        run_job(0, 1'b0, 0, 1'b0, 1);

        // Gapped beats, ignored mid-run start, result held for five cycles.
        beat_q = {32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
        run_job(4, 1'b0, 1, 1'b1, 5);
        check("idle_not_busy", 64'(busy_o), 64'd0);

        // Reset in the middle of a five-beat job.
        beat_q = {32'h05050505, 32'h05050505, 32'h05050505, 32'h05050505, 32'h05050505};
        start_i     = 1'b1;
        num_words_i = 12'd5;
        sat_en_i    = 1'b0;
        tick();
        start_i = 1'b0;
        feed(2, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(ready_o), 64'd0);
        check("abort_valid", 64'(valid_o), 64'd0);
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_ovf", 64'(ovf_o), 64'd0);
        check("abort_result", result_o, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        beat_q = {32'h01010101};
        run_job(1, 1'b0, 0, 1'b0, 1);

        // Randomized jobs.
        for (int j = 0; j < 25; j++) begin
            nw    = int'($urandom_range(0, 350));
            heavy = 1'($urandom_range(0, 1));
            beat_q.delete();
            for (int i = 0; i < nw; i++)
                beat_q.push_back(heavy ? ($urandom | 32'hC0C0C0C0) : $urandom);
            run_job(nw, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)));
            repeat (int'($urandom_range(0, 2))) tick();
        end

        tick();
        tick();
        check("results_outstanding", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
